// File: rtl/decap_header_stripper.sv
`default_nettype none
// decap_header_stripper (rev 1.0): strips the outer Ethernet+IPv4 header from matching
// encapsulated AXI-Stream frames and realigns the inner frame to byte 0; other frames pass through.
module decap_header_stripper #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int STRIP_BYTES        = 34
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  input  logic                            decap_begin,
  input  logic [7:0]                      encap_proto
);

  localparam int BYTES = C_AXIS_DATA_WIDTH / 8;
  localparam int OFF   = STRIP_BYTES - BYTES;  // header bytes still present in beat 1
  localparam int RES   = BYTES - OFF;          // residual bytes carried between beats

  typedef enum logic [2:0] {
    ST_FIRST     = 3'd0,
    ST_PASS      = 3'd1,
    ST_DROP_WAIT = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_FLUSH     = 3'd4
  } state_t;

  state_t                          state_q, state_d;
  logic [C_AXIS_DATA_WIDTH-1:0]    res_data_q, res_data_d;
  logic [BYTES-1:0]                res_keep_q, res_keep_d;
  logic [C_AXIS_TUSER_WIDTH-1:0]   user_q, user_d;
  logic [C_AXIS_DATA_WIDTH-1:0]    m_data_q, m_data_d;
  logic [BYTES-1:0]                m_keep_q, m_keep_d;
  logic [C_AXIS_TUSER_WIDTH-1:0]   m_user_q, m_user_d;
  logic                            m_valid_q, m_valid_d;
  logic                            m_last_q, m_last_d;

  logic                            m_free;
  logic                            s_fire;
  logic                            strip;
  logic [C_AXIS_DATA_WIDTH-1:0]    din;

  // Bytes outside tkeep are zeroed on entry so every shifted beat is clean.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_mask
    assign din[8*gi +: 8] = s_axis_tkeep[gi] ? s_axis_tdata[8*gi +: 8] : 8'h00;
  end

  assign m_free        = !m_valid_q || m_axis_tready;
  assign s_axis_tready = !ARESET && m_free && (state_q != ST_FLUSH);
  assign s_fire        = s_axis_tvalid && s_axis_tready;

  assign strip = decap_begin
              && (s_axis_tdata[8*12 +: 8] == 8'h08)
              && (s_axis_tdata[8*13 +: 8] == 8'h00)
              && (s_axis_tdata[8*23 +: 8] == encap_proto)
              && (s_axis_tuser[15:0] > 16'(STRIP_BYTES));

  always_comb begin
    state_d    = state_q;
    res_data_d = res_data_q;
    res_keep_d = res_keep_q;
    user_d     = user_q;
    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    m_user_d   = m_user_q;
    m_last_d   = m_last_q;
    m_valid_d  = m_valid_q && !m_axis_tready;

    unique case (state_q)
      ST_FIRST: begin
        if (s_fire) begin
          if (strip) begin
            user_d        = s_axis_tuser;
            user_d[15:0]  = s_axis_tuser[15:0] - 16'(STRIP_BYTES);
            state_d       = s_axis_tlast ? ST_FIRST : ST_DROP_WAIT;
          end else begin
            m_valid_d = 1'b1;
            m_data_d  = din;
            m_keep_d  = s_axis_tkeep;
            m_user_d  = s_axis_tuser;
            m_last_d  = s_axis_tlast;
            state_d   = s_axis_tlast ? ST_FIRST : ST_PASS;
          end
        end
      end

      ST_PASS: begin
        if (s_fire) begin
          m_valid_d = 1'b1;
          m_data_d  = din;
          m_keep_d  = s_axis_tkeep;
          m_user_d  = s_axis_tuser;
          m_last_d  = s_axis_tlast;
          if (s_axis_tlast) state_d = ST_FIRST;
        end
      end

      ST_DROP_WAIT: begin
        if (s_fire) begin
          res_data_d = din >> (8 * OFF);
          res_keep_d = s_axis_tkeep >> OFF;
          if (s_axis_tlast) begin
            state_d = s_axis_tkeep[OFF] ? ST_FLUSH : ST_FIRST;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        if (s_fire) begin
          m_valid_d  = 1'b1;
          m_data_d   = res_data_q | (din << (8 * RES));
          m_keep_d   = res_keep_q | (s_axis_tkeep << RES);
          m_user_d   = user_q;
          // Bit OFF of tkeep set means the beat overflows the output and needs a flush beat.
          m_last_d   = s_axis_tlast && !s_axis_tkeep[OFF];
          res_data_d = din >> (8 * OFF);
          res_keep_d = s_axis_tkeep >> OFF;
          if (s_axis_tlast) state_d = s_axis_tkeep[OFF] ? ST_FLUSH : ST_FIRST;
        end
      end

      ST_FLUSH: begin
        if (m_free) begin
          m_valid_d = 1'b1;
          m_data_d  = res_data_q;
          m_keep_d  = res_keep_q;
          m_user_d  = user_q;
          m_last_d  = 1'b1;
          state_d   = ST_FIRST;
        end
      end

      default: state_d = ST_FIRST;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= ST_FIRST;
      res_data_q <= '0;
      res_keep_q <= '0;
      user_q     <= '0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_user_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_data_q <= res_data_d;
      res_keep_q <= res_keep_d;
      user_q     <= user_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_user_q   <= m_user_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;

endmodule
`default_nettype wire

// File: tb/tb_decap_header_stripper.sv
`default_nettype none
// tb_decap_header_stripper: random and directed frames against a byte-level reference model.
module tb_decap_header_stripper;

  localparam logic [7:0] PROTO = 8'h04;
  localparam int         STRIP = 34;

  logic          ACLK;
  logic          ARESET;
  logic [255:0]  s_axis_tdata;
  logic [31:0]   s_axis_tkeep;
  logic [127:0]  s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [255:0]  m_axis_tdata;
  logic [31:0]   m_axis_tkeep;
  logic [127:0]  m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic          decap_begin;
  logic [7:0]    encap_proto;

  decap_header_stripper #(
    .C_AXIS_DATA_WIDTH (256),
    .C_AXIS_TUSER_WIDTH(128),
    .STRIP_BYTES       (STRIP)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .decap_begin  (decap_begin),
    .encap_proto  (encap_proto)
  );

  typedef struct {
    logic [255:0] d;
    logic [31:0]  k;
    logic [127:0] u;
    logic         l;
  } beat_t;

  beat_t       exp_q[$];
  logic [7:0]  fb [0:255];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_exp    = 0;
  int          n_rx     = 0;
  int          ready_mode = 0;  // 0 always ready, 1 random, 2 never ready

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin : ready_drv
    m_axis_tready = 1'b1;
    forever begin
      @(posedge ACLK);
      #2;
      case (ready_mode)
        0:       m_axis_tready = 1'b1;
        2:       m_axis_tready = 1'b0;
        default: m_axis_tready = ($urandom % 3) != 0;
      endcase
    end
  end

  initial begin : monitor
    beat_t        e;
    bit           stalled;
    logic [417:0] held;
    stalled = 0;
    held    = '0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        stalled = 0;
      end else begin
        if (stalled)
          check("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tuser, m_axis_tdata}, held);
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            n_rx++;
            check("out_data", m_axis_tdata, e.d);
            check("out_keep", m_axis_tkeep, e.k);
            check("out_user", m_axis_tuser, e.u);
            check("out_last", m_axis_tlast, e.l);
          end
        end
        stalled = m_axis_tvalid && !m_axis_tready;
        held    = {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tuser, m_axis_tdata};
      end
    end
  end

  // Reference: output bytes are the frame minus the header when stripping, cut into 32-byte beats.
  task automatic model_frame(input int len, input logic [127:0] tu, input bit strip);
    int           start;
    int           plen;
    logic [127:0] eu;
    beat_t        e;
    start = strip ? STRIP : 0;
    plen  = len - start;
    eu    = tu;
    if (strip) eu[15:0] = 16'(plen);
    for (int o = 0; o < plen; o += 32) begin
      e.d = '0;
      e.k = '0;
      e.u = eu;
      e.l = (o + 32 >= plen);
      for (int i = 0; i < 32 && o + i < plen; i++) begin
        e.d[8*i +: 8] = fb[start + o + i];
        e.k[i]        = 1'b1;
      end
      exp_q.push_back(e);
      n_exp++;
    end
  endtask

  task automatic send_beat();
    int t;
    t = 0;
    s_axis_tvalid = 1'b1;
    do begin
      @(negedge ACLK);
      t++;
    end while (!s_axis_tready && t < 1000);
    if (!s_axis_tready) begin
      check("s_ready_timeout", s_axis_tready, 1);
      s_axis_tvalid = 1'b0;
      return;
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_frame(input int len, input bit decap, input bit encap, input bit pmatch,
                            input bit lat_chk, input int beat_lim);
    logic [127:0] tu;
    bit           strip;
    int           nb;
    int           nsend;
    int           vb;
    for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
    if (encap) begin
      fb[12] = 8'h08;
      fb[13] = 8'h00;
      fb[23] = pmatch ? PROTO : (PROTO ^ 8'h5A);
    end
    tu        = {$urandom, $urandom, $urandom, $urandom};
    tu[15:0]  = 16'(len);
    strip     = decap && fb[12] == 8'h08 && fb[13] == 8'h00 && fb[23] == PROTO && len > STRIP;
    nb        = (len + 31) / 32;
    nsend     = (beat_lim > 0 && beat_lim < nb) ? beat_lim : nb;
    if (beat_lim == 0) model_frame(len, tu, strip);
    for (int b = 0; b < nsend; b++) begin
      vb = (len - 32*b >= 32) ? 32 : len - 32*b;
      for (int i = 0; i < 32; i++) begin
        s_axis_tkeep[i]         = (i < vb);
        s_axis_tdata[8*i +: 8]  = (i < vb) ? fb[32*b + i] : 8'($urandom);
      end
      s_axis_tuser = tu;
      s_axis_tlast = (b == nb - 1);
      decap_begin  = (b == 0) ? decap : 1'($urandom);
      if (!lat_chk && ($urandom % 4) == 0) begin
        s_axis_tvalid = 1'b0;
        @(posedge ACLK);
        #1;
      end
      send_beat();
      if (lat_chk) begin
        check("lat_valid", m_axis_tvalid, strip ? (b >= 2) : 1'b1);
        if (strip && b == nb - 1 && vb > STRIP - 32)
          check("flush_ready_low", s_axis_tready, 1'b0);
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge ACLK);
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (2) @(posedge ACLK);
    #1;
  endtask

  initial begin : main
    ARESET        = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    decap_begin   = 1'b0;
    encap_proto   = PROTO;
    repeat (3) @(posedge ACLK);
    #1;
    check("reset_outputs", {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tuser, m_axis_tdata}, '0);
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;

    // Directed cases: pass-through, strip with and without flush, near-miss headers, length edges.
    send_frame(96, 0, 1, 1, 1, 0);
    send_frame(66, 1, 1, 1, 1, 0);
    send_frame(96, 1, 1, 1, 1, 0);
    send_frame(96, 1, 1, 0, 1, 0);
    send_frame(34, 1, 1, 1, 1, 0);
    send_frame(35, 1, 1, 1, 1, 0);
    send_frame(64, 1, 1, 1, 1, 0);
    send_frame(67, 1, 1, 1, 1, 0);
    send_frame(20, 1, 1, 1, 1, 0);
    drain();

    ready_mode = 1;
    for (int f = 0; f < 150; f++)
      send_frame($urandom_range(1, 200), ($urandom % 4) != 0, ($urandom % 4) != 0,
                 ($urandom % 4) != 0, 0, 0);
    drain();

    // Abort a stripped frame while it is in the shifting phase, then restart cleanly.
    ready_mode = 2;
    @(posedge ACLK);
    #1;
    send_frame(128, 1, 1, 1, 0, 3);
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    check("midreset_outputs", {s_axis_tready, m_axis_tvalid, m_axis_tkeep}, '0);
    ARESET     = 1'b0;
    ready_mode = 0;
    @(posedge ACLK);
    #1;
    check("post_reset_valid", m_axis_tvalid, 1'b0);
    send_frame(66, 1, 1, 1, 1, 0);
    drain();

    check("beat_count", n_rx, n_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decap_header_stripper.md
DECAP_HEADER_STRIPPER -- requirements
Module: decap_header_stripper

Interface
REQ-001 Parameter C_AXIS_DATA_WIDTH, default 256, stream data width in bits (32 bytes/beat).
REQ-002 Parameter C_AXIS_TUSER_WIDTH, default 128, sideband width; tuser[15:0] = frame length in bytes.
REQ-003 Parameter STRIP_BYTES, default 34, outer Ethernet (14) + IPv4 (20) header length; supported only in range 33..63.
REQ-004 ACLK  in  1  sole clock, all logic rising-edge.
REQ-005 ARESET  in  1  synchronous, active-high reset.
REQ-006 s_axis_tdata/tkeep/tuser/tvalid/tlast  in  256/32/128/1/1  input frame, byte n at tdata[8n+7:8n], tkeep contiguous from bit 0.
REQ-007 s_axis_tready  out  1  input accept.
REQ-008 m_axis_tdata/tkeep/tuser/tvalid/tlast  out  256/32/128/1/1  output frame, same byte order.
REQ-009 m_axis_tready  in  1  output accept.
REQ-010 decap_begin  in  1  decision for the frame whose first beat is on s_axis, valid during that beat.
REQ-011 encap_proto  in  8  IP protocol number identifying encapsulated frames.

Function
REQ-012 Transfer occurs on tvalid&&tready; first beat = first transfer after reset or after a tlast transfer.
REQ-013 Strip decision on first beat: strip = decap_begin && byte12==0x08 && byte13==0x00 && byte23==encap_proto && tuser[15:0] > STRIP_BYTES; latched for the whole frame.
REQ-014 States: FIRST, PASS, DROP_WAIT, SHIFT, FLUSH.
REQ-015 FIRST: strip=0 -> beat forwarded unchanged, next PASS (FIRST if tlast); strip=1 -> beat discarded, tuser latched with tuser[15:0]-STRIP_BYTES, next DROP_WAIT.
REQ-016 PASS: beats forwarded unchanged; tlast -> FIRST.
REQ-017 DROP_WAIT: beat 1 bytes [STRIP_BYTES-32 .. 31] stored as residual (R = 64-STRIP_BYTES bytes, 30 by default), nothing emitted, next SHIFT.
REQ-018 SHIFT: each input beat k emits residual || beat k bytes [0 .. 31-R], residual := beat k bytes [32-R .. 31].
REQ-019 SHIFT, tlast with valid bytes V <= 32-R: single output beat, tlast=1, tkeep = R+V low bits set, next FIRST.
REQ-020 SHIFT, tlast with V > 32-R: output full beat tlast=0, next FLUSH; FLUSH emits residual of V-(32-R) bytes with tlast=1, s_axis_tready=0, next FIRST after acceptance.
REQ-021 Stripped frame whose tlast arrives on beat 1: residual emitted directly as final beat (FLUSH path) with tkeep of V-(STRIP_BYTES-32) bytes.
REQ-022 m_axis_tuser on every beat of a stripped frame = latched adjusted tuser; pass frames carry input tuser unchanged.
REQ-023 Output is a single register stage: s_axis_tready = (!m_axis_tvalid || m_axis_tready) && state!=FLUSH; latency first-kept-byte to output = 1 cycle in PASS, 2 beats in strip.
REQ-024 m_axis signals held stable while m_axis_tvalid && !m_axis_tready.
REQ-025 Output tkeep bytes beyond last valid byte and their tdata driven 0.
REQ-026 Frame length arithmetic 16-bit unsigned; no wrap possible due to REQ-013 guard.

Reset
REQ-027 ARESET high at a clock edge: state=FIRST, residual and latched tuser=0, m_axis_tvalid=0, m_axis_tdata/tkeep/tuser/tlast=0, s_axis_tready=0 during reset.
REQ-028 Reset mid-frame discards the partial frame; first transfer after release is treated as first beat.

Verification
REQ-029 decap_begin=0, 96-byte frame -> identical 3 beats out, tuser unchanged, 1-cycle latency.
REQ-030 Strip, 66-byte frame (32,32,2), proto match -> one beat, 32 bytes = input bytes 34..65, tkeep 0xFFFFFFFF, tlast=1, tuser[15:0]=32.
REQ-031 Strip, 96-byte frame -> two beats: 32 bytes, then 30 bytes tkeep 0x3FFFFFFF tlast=1; tuser[15:0]=62; s_axis_tready low during FLUSH.
REQ-032 decap_begin=1 but byte23!=encap_proto, or 34-byte frame -> passes unchanged.
REQ-033 Random m_axis_tready backpressure over back-to-back mixed frames -> byte stream matches model, no drop/duplicate, outputs stable while stalled.
REQ-034 ARESET asserted in SHIFT mid-frame, then new 66-byte strip frame -> m_axis_tvalid=0 after reset, new frame output per REQ-030.
